// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the buffered UART transmitter.
// Holds the transmit FSM state encoding and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int baud_divisor(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-write bus between the store path (master) and the
// UART transmitter (slave), including the FIFO status flags.
interface uart_tx_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          WE;
  logic [7:0]    WD;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;

  modport master (
    output WE,
    output WD,
    input  full,
    input  empty,
    input  count,
    input  busy
  );

  modport slave (
    input  WE,
    input  WD,
    output full,
    output empty,
    output count,
    output busy
  );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with one extra pointer bit so that full and
// empty are told apart without a separate occupancy register.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped; a pop while empty is ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 transmitter. Bytes are queued in a small FIFO and
// serialized LSB first with one start and one stop bit at a fixed rate.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_if.slave       bus,
  output logic           uartTxPin
);

  localparam int DIVISOR = baud_divisor(CLK_FREQ, BAUD);
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             pin_d;
  logic             pop;
  logic             bit_done;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [7:0]       fifo_dout;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (bus.WE),
    .pop   (pop),
    .din   (bus.WD),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.full  = fifo_full;
  assign bus.empty = fifo_empty;
  assign bus.count = fifo_count;
  assign bus.busy  = (state_q != TX_IDLE) || !fifo_empty;

  assign bit_done = (cnt_q == '0);

  // Next-state logic: bit timing, shifting and FIFO pops at frame starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          cnt_d   = RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = RELOAD;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the next state so the pin
  // can be a plain register with no glitches.
  always_comb begin
    pin_d = 1'b1;
    case (state_d)
      TX_IDLE:  pin_d = 1'b1;
      TX_START: pin_d = 1'b0;
      TX_DATA:  pin_d = shift_d[0];
      TX_STOP:  pin_d = 1'b1;
      default:  pin_d = 1'b1;
    endcase
  end

  // State register; reset abandons any frame and parks the line high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      uartTxPin <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uartTxPin <= pin_d;
    end
  end

endmodule
